// File: rtl/i2c_rx_pkg.sv
// rtl/i2c_rx_pkg.sv - shared constants and FSM state type for the I2C read-data capture block
//
// Contents:
//   RX_DEPTH_DEFAULT : default RX FIFO depth in bytes (power of two)
//   BYTE_W           : width of one captured I2C data byte
//   rx_state_e       : capture FSM states
package i2c_rx_pkg;

    localparam int RX_DEPTH_DEFAULT = 8;
    localparam int BYTE_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_PUSH     = 2'd2,
        ST_WAIT_LOW = 2'd3
    } rx_state_e;

endpackage

// File: rtl/i2c_rx_capture_if.sv
// rtl/i2c_rx_capture_if.sv - register-side interface of the I2C read-data capture block
//
// Signals:
//   rd_en, clr_err           : pop request and sticky-flag clear (from register side)
//   rd_data                  : FIFO head byte, first-word fall-through
//   empty, full, count       : FIFO status / occupancy
//   byte_done                : one-cycle pulse per captured byte
//   overflow, frame_err      : sticky error flags
// Modports:
//   master : register side (drives rd_en/clr_err)
//   slave  : capture block
interface i2c_rx_capture_if
    import i2c_rx_pkg::*;
#(
    parameter int DEPTH = RX_DEPTH_DEFAULT
);

    logic                     rd_en;
    logic                     clr_err;
    logic [BYTE_W-1:0]        rd_data;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     byte_done;
    logic                     overflow;
    logic                     frame_err;

    modport master (
        output rd_en,
        output clr_err,
        input  rd_data,
        input  empty,
        input  full,
        input  count,
        input  byte_done,
        input  overflow,
        input  frame_err
    );

    modport slave (
        input  rd_en,
        input  clr_err,
        output rd_data,
        output empty,
        output full,
        output count,
        output byte_done,
        output overflow,
        output frame_err
    );

endinterface

// File: rtl/i2c_rx_fifo.sv
// rtl/i2c_rx_fifo.sv - first-word fall-through byte FIFO for captured I2C read data
//
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   push       : write request, wdata is the byte to store
//   pop_req    : read request; ignored while empty
//   rdata      : mem[rd_ptr], valid whenever not empty
//   empty/full : occupancy is 0 / DEPTH
//   count      : occupancy
//   drop       : one-cycle pulse when a push was refused because the FIFO was full
module i2c_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop_req,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop;
    logic             push_ok;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        pop     = pop_req && !empty;
        // A full FIFO still takes the byte when a pop frees a slot in the same cycle.
        push_ok = push && (!full || pop);
        drop    = push && !push_ok;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push_ok) - CW'(pop);

        rdata = mem_q[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: content is only visible through a non-empty FIFO.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/i2c_rx_capture.sv
// rtl/i2c_rx_capture.sv - captures I2C read-data bytes from SCL/SDA into an RX FIFO
//
// Ports:
//   core_clk  : system clock, rising edge
//   rst       : synchronous active-high reset
//   scl_in    : SCL line (asynchronous, synchronized here)
//   sda_in    : SDA line (asynchronous, synchronized here)
//   rx_enable : read-data-phase flag, high for the 8 data bits of a byte
//   reg_if    : register-side interface (FIFO read port, status, sticky errors)
module i2c_rx_capture
    import i2c_rx_pkg::*;
#(
    parameter int DEPTH       = RX_DEPTH_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                core_clk,
    input  logic                rst,
    input  logic                scl_in,
    input  logic                sda_in,
    input  logic                rx_enable,
    i2c_rx_capture_if.slave     reg_if
);

    localparam int CNT_W = $clog2(BYTE_W) + 1;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]      shreg_q, shreg_d;
    logic                   byte_done_q, byte_done_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;
    logic                   frame_set;
    logic                   fifo_drop;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_prev_d = scl_s;
        scl_rise   = scl_s && !scl_prev_q;

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        frame_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_enable) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (scl_rise) begin
                    shreg_d   = {shreg_q[BYTE_W-2:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                // A completing 8th rise wins over rx_enable dropping in the same cycle;
                // otherwise an early drop abandons the partial byte.
                if (scl_rise && (bit_cnt_q == CNT_W'(BYTE_W - 1))) begin
                    state_d = ST_PUSH;
                end else if (!rx_enable) begin
                    state_d   = ST_IDLE;
                    frame_set = 1'b1;
                end
            end
            ST_PUSH: begin
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                // SCL rises here belong to the ACK bit and are not sampled.
                if (!rx_enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        byte_done_d = (state_d == ST_PUSH);
        frame_err_d = frame_set || (frame_err_q && !reg_if.clr_err);
        overflow_d  = fifo_drop || (overflow_q && !reg_if.clr_err);
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // byte_done_q is high exactly in the PUSH cycle, so it doubles as the FIFO write strobe.
    i2c_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk     (core_clk),
        .rst     (rst),
        .push    (byte_done_q),
        .wdata   (shreg_q),
        .pop_req (reg_if.rd_en),
        .rdata   (reg_if.rd_data),
        .empty   (reg_if.empty),
        .full    (reg_if.full),
        .count   (reg_if.count),
        .drop    (fifo_drop)
    );

    assign reg_if.byte_done = byte_done_q;
    assign reg_if.frame_err = frame_err_q;
    assign reg_if.overflow  = overflow_q;

endmodule
